address_unit: RTL

ADDRESS_UNIT -- requirements
Module: address_unit

---
 rtl/cpu6502_pkg.sv | 41 ++++
 rtl/address_unit_if.sv | 30 +++
 rtl/address_unit_addr_mux.sv | 25 ++
 rtl/address_unit.sv | 106 ++++++++++
 4 files changed

// File: rtl/cpu6502_pkg.sv
// Shared CPU definitions: bus address source encodings, reset vector addresses,
// vector-fetch states and the pointer-register bundle.
package cpu6502_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned SEL_W  = 3;

    typedef enum logic [SEL_W-1:0] {
        ADDR_PC         = 3'd0,
        ADDR_ZERO       = 3'd1,
        ADDR_ABS        = 3'd2,
        ADDR_IND_ZERO_0 = 3'd3,
        ADDR_IND_ZERO_1 = 3'd4,
        ADDR_IND_ABS_0  = 3'd5,
        ADDR_IND_ABS_1  = 3'd6
    } addr_sel_e;

    localparam logic [ADDR_W-1:0] VEC_LO_ADDR = 16'hFFFC;
    localparam logic [ADDR_W-1:0] VEC_HI_ADDR = 16'hFFFD;

    typedef enum logic [1:0] {
        VEC_LO = 2'd0,
        VEC_HI = 2'd1,
        RUN    = 2'd2
    } vec_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] ind_h;
        logic [DATA_W-1:0] ind_l;
        logic [DATA_W-1:0] dir_h;
        logic [DATA_W-1:0] dir_l;
    } ptr_regs_t;

    // PC plus a signed 8-bit displacement, wrapping modulo 64K.
    function automatic logic [ADDR_W-1:0] pc_rel(input logic [ADDR_W-1:0] pc,
                                                 input logic [DATA_W-1:0] off);
        return pc + {{(ADDR_W-DATA_W){off[DATA_W-1]}}, off};
    endfunction

endpackage

// File: rtl/address_unit_if.sv
// Control-unit <-> address-unit signal bundle; the control side is the master.
interface address_unit_if;
    import cpu6502_pkg::*;

    logic              increment_pc;
    logic              indirl_load;
    logic              indirh_load;
    logic              dirl_load;
    logic              dirh_load;
    logic              branch_load;
    logic [SEL_W-1:0]  address_select;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] alu_result;
    logic [ADDR_W-1:0] address;
    logic [ADDR_W-1:0] pc;
    logic              busy;

    modport master (
        output increment_pc, indirl_load, indirh_load, dirl_load, dirh_load,
               branch_load, address_select, data_in, alu_result,
        input  address, pc, busy
    );

    modport slave (
        input  increment_pc, indirl_load, indirh_load, dirl_load, dirh_load,
               branch_load, address_select, data_in, alu_result,
        output address, pc, busy
    );

endinterface

// File: rtl/address_unit_addr_mux.sv
// Combinational bus-address selector over PC and the direct/indirect pointer bytes.
module addr_mux
    import cpu6502_pkg::*;
(
    input  logic [SEL_W-1:0]  sel_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  ptr_regs_t         ptr_i,
    output logic [ADDR_W-1:0] addr_c_o
);

    always_comb begin
        addr_c_o = pc_i;
        case (sel_i)
            ADDR_ZERO:       addr_c_o = {8'h00, ptr_i.dir_l};
            ADDR_ABS:        addr_c_o = {ptr_i.dir_h, ptr_i.dir_l};
            ADDR_IND_ZERO_0: addr_c_o = {8'h00, ptr_i.ind_l};
            // second pointer byte stays inside page zero
            ADDR_IND_ZERO_1: addr_c_o = {8'h00, ptr_i.ind_l + 8'd1};
            ADDR_IND_ABS_0:  addr_c_o = {ptr_i.ind_h, ptr_i.ind_l};
            ADDR_IND_ABS_1:  addr_c_o = {ptr_i.ind_h, ptr_i.ind_l} + 16'd1;
            default:         addr_c_o = pc_i;
        endcase
    end

endmodule

// File: rtl/address_unit.sv
// CPU address unit: program counter, pointer registers and bus address selection.
// Define ADDRESS_UNIT_VECTOR_EN to fetch the start PC from FFFC/FFFD after reset.
module address_unit
    import cpu6502_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0200
) (
    input  logic           clk,
    input  logic           rst,
    address_unit_if.slave  bus
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    ptr_regs_t         ptr_q, ptr_d;
    logic              busy_c;
    logic [ADDR_W-1:0] mux_addr_c;

`ifdef ADDRESS_UNIT_VECTOR_EN
    localparam logic [ADDR_W-1:0] PC_RST = '0;

    vec_state_e state_q, state_d;
    logic       busy_q, busy_d;

    // Vector-fetch state register; reset always restarts the fetch at VEC_LO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= VEC_LO;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            VEC_LO:  state_d = VEC_HI;
            VEC_HI:  state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = VEC_LO;
        endcase
        busy_d = (state_d != RUN);
    end

    assign busy_c      = busy_q;
    assign bus.address = busy_c ? ((state_q == VEC_HI) ? VEC_HI_ADDR : VEC_LO_ADDR)
                                : mux_addr_c;
`else
    localparam logic [ADDR_W-1:0] PC_RST = RESET_PC;

    assign busy_c      = 1'b0;
    assign bus.address = mux_addr_c;
`endif

    addr_mux u_addr_mux (
        .sel_i    (bus.address_select),
        .pc_i     (pc_q),
        .ptr_i    (ptr_q),
        .addr_c_o (mux_addr_c)
    );

    // Next-state for PC, pointer bytes and the read-data latch; strobes are dead while busy.
    always_comb begin
        pc_d    = pc_q;
        rdata_d = rdata_q;
        ptr_d   = ptr_q;

        if (!busy_c) begin
            rdata_d = bus.data_in;
            if (bus.indirl_load) ptr_d.ind_l = bus.data_in;
            if (bus.indirh_load) ptr_d.ind_h = bus.data_in;
            if (bus.dirl_load)   ptr_d.dir_l = bus.alu_result;
            if (bus.dirh_load)   ptr_d.dir_h = bus.alu_result;
            // branch offset is the byte latched on the previous cycle
            if (bus.branch_load) begin
                pc_d = pc_rel(pc_q, rdata_q);
            end else if (bus.increment_pc) begin
                pc_d = pc_q + 16'd1;
            end
        end
`ifdef ADDRESS_UNIT_VECTOR_EN
        else begin
            if (state_q == VEC_HI) pc_d[15:8] = bus.data_in;
            else                   pc_d[7:0]  = bus.data_in;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q    <= PC_RST;
            rdata_q <= '0;
            ptr_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            rdata_q <= rdata_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.pc   = pc_q;
    assign bus.busy = busy_c;

endmodule
